sample_pacer: RTL and testbench
===============================

SAMPLE_PACER -- requirements
Module: sample_pacer

Interface
REQ-001 SHALL have parameter N, default 32, width of freq_count and internal period counter.
REQ-002 SHALL have parameter WORD_W, default 32, width of the upstream sample word.
REQ-003 SHALL have parameter SAMPLE_W, default 8, width of one audio sample; WORD_W/SAMPLE_W = 4 samples per word.
REQ-004 clk_in  input  1  sole clock (50 MHz); all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-006 enable  input  1  playback enable; low = paused.
REQ-007 freq_count  input  N  clk_in cycles per sample period, driven by the frequency controller (614 default, 1..4000 nominal).
REQ-008 word_valid  input  1  upstream word available.
REQ-009 word_data  input  WORD_W  packed samples, byte 0 = bits [7:0] played first.
REQ-010 word_ready  output  1  block can accept a word.
REQ-011 sample_out  output  SAMPLE_W  current audio sample, registered, held between updates.
REQ-012 sample_strobe  output  1  one-cycle pulse, high in the cycle sample_out takes a new value.
REQ-013 underrun  output  1  one-cycle pulse, sample period expired with no buffered sample.

Function
REQ-014 Period counter SHALL count 0,1,2,... while enable=1 and generate internal tick in the cycle counter >= eff-1, where eff = max(freq_count,1); on tick counter returns to 0.
REQ-015 Tick period SHALL be exactly eff cycles for constant freq_count; freq_count=0 and freq_count=1 both tick every enabled cycle.
REQ-016 freq_count SHALL be compared live (not latched); if freq_count drops to or below counter+1 mid-period, tick SHALL occur in that same cycle.
REQ-017 enable=0 SHALL hold counter at 0, suppress tick, hold byte index and buffer; first tick after enable rises occurs eff cycles later.
REQ-018 Buffer FSM SHALL have states EMPTY and FULL plus 2-bit byte index idx.
REQ-019 word_ready SHALL equal (state==EMPTY), independent of enable.
REQ-020 Transfer SHALL occur on rising edge with word_valid=1 and word_ready=1: word captured, idx<=0, state<=FULL.
REQ-021 Tick in FULL SHALL register sample_out<=byte[idx], sample_strobe<=1 (visible next cycle, latency 1 clock from tick), idx<=idx+1.
REQ-022 Tick in FULL with idx=3 SHALL additionally set state<=EMPTY, so word_ready rises the cycle after the last byte is emitted.
REQ-023 Tick in EMPTY SHALL register underrun<=1, leave sample_out unchanged, sample_strobe<=0.
REQ-024 Tick and transfer in the same cycle while EMPTY SHALL count as underrun; the new word's byte 0 is emitted on the next tick.
REQ-025 sample_strobe and underrun SHALL never be high in the same cycle; both low in all non-tick-following cycles.
REQ-026 Samples SHALL pass through bit-exact (no sign conversion, scaling or clamping).

Reset
REQ-027 reset=0 SHALL immediately (asynchronously) force: counter=0, state=EMPTY, idx=0, sample_out=0, sample_strobe=0, underrun=0, word_ready=1.
REQ-028 Reset asserted mid-word SHALL discard remaining buffered bytes; after release, first tick with no new word produces underrun.
REQ-029 Outputs SHALL stay at reset values while reset=0 regardless of enable, word_valid or freq_count.

Verification
REQ-030 Reset: drive reset=0 mid-period with FULL buffer -> same-timestep sample_out=0x00, strobe=0, underrun=0, word_ready=1.
REQ-031 Unpack: freq_count=4, enable=1, load 0xDDCCBBAA -> strobes every 4 cycles with sample_out AA, BB, CC, DD; word_ready=1 one cycle after DD strobe tick.
REQ-032 Underrun: freq_count=3, word_valid=0 -> underrun pulse every 3 cycles, no strobe, sample_out holds last value.
REQ-033 Extremes: freq_count=1 then 0 -> tick every cycle; with word_valid held high, continuous strobes, 4 per word, one underrun per refill gap.
REQ-034 Live change: freq_count=10, counter reaches 6, drive freq_count=2 -> tick that cycle, then period of 2 cycles.
REQ-035 Pause: enable=0 after 2nd byte for 20 cycles -> no strobe/underrun; enable=1 -> 3rd byte strobed eff cycles later.

Source files
------------

// File: rtl/sample_pacer.sv
// rtl/sample_pacer.sv - paces buffered audio words out as one sample per freq_count cycles
module sample_pacer #(
  parameter int N        = 32,
  parameter int WORD_W   = 32,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  input  logic [N-1:0]        freq_count,
  input  logic                word_valid,
  input  logic [WORD_W-1:0]   word_data,
  output logic                word_ready,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_strobe,
  output logic                underrun
);

  localparam int SPW   = WORD_W / SAMPLE_W;
  localparam int IDX_W = (SPW > 1) ? $clog2(SPW) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  logic [N-1:0]        cnt_q, cnt_d, eff;
  logic                tick;
  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WORD_W-1:0]   word_q, shifted;
  logic [SAMPLE_W-1:0] sample_q;
  logic                strobe_q, underrun_q;

  // freq_count is compared live so a shortened period takes effect immediately
  always_comb begin
    eff   = (freq_count == '0) ? N'(1) : freq_count;
    tick  = enable && (cnt_q >= eff - N'(1));
    cnt_d = cnt_q + N'(1);
    if (!enable || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign shifted = word_q >> (idx_q * SAMPLE_W);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      idx_q      <= '0;
      word_q     <= '0;
      sample_q   <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      case (state_q)
        EMPTY: begin
          // a tick landing on the refill cycle is still an underrun
          if (tick) begin
            underrun_q <= 1'b1;
          end
          if (word_valid) begin
            word_q  <= word_data;
            idx_q   <= '0;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (tick) begin
            sample_q <= shifted[SAMPLE_W-1:0];
            strobe_q <= 1'b1;
            idx_q    <= idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(SPW - 1)) begin
              state_q <= EMPTY;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign word_ready    = (state_q == EMPTY);
  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_sample_pacer.sv
// tb/tb_sample_pacer.sv - scoreboard bench for sample_pacer against a byte-queue reference model
module tb_sample_pacer;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] freq_count = 32'd614;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_ready;
  logic [7:0]  sample_out;
  logic        sample_strobe;
  logic        underrun;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         is_strobe;
    logic [7:0] val;
  } ev_t;

  logic [7:0]  bq[$];
  ev_t         sb[$];
  logic [7:0]  exp_sample = '0;
  int unsigned elapsed = 0;
  int unsigned eff_m;
  bit          tick_m;
  bit          was_empty;
  ev_t         got;

  sample_pacer dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .enable       (enable),
    .freq_count   (freq_count),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .sample_out   (sample_out),
    .sample_strobe(sample_strobe),
    .underrun     (underrun)
  );

  always #5 clk_in = ~clk_in;

  // Reference: enabled cycles since the last tick, and a plain queue of pending bytes
  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      elapsed    = 0;
      exp_sample = '0;
      bq.delete();
      sb.delete();
    end else begin
      eff_m     = (freq_count == 0) ? 1 : freq_count;
      tick_m    = 1'b0;
      was_empty = (bq.size() == 0);
      if (!enable) begin
        elapsed = 0;
      end else if (elapsed + 1 >= eff_m) begin
        tick_m  = 1'b1;
        elapsed = 0;
      end else begin
        elapsed = elapsed + 1;
      end
      if (tick_m) begin
        if (!was_empty) begin
          exp_sample = bq.pop_front();
          sb.push_back('{1'b1, exp_sample});
        end else begin
          sb.push_back('{1'b0, exp_sample});
        end
      end
      if (was_empty && word_valid) begin
        for (int k = 0; k < 4; k++) begin
          bq.push_back(word_data[8*k +: 8]);
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (reset) begin
      tests++;
      if (word_ready !== (bq.size() == 0)) begin
        fails++;
        $display("FAIL word_ready: got %b want %b at %0t", word_ready, bq.size() == 0, $time);
      end
      tests++;
      if (sample_strobe && underrun) begin
        fails++;
        $display("FAIL both_pulses: strobe=1 underrun=1 want not both at %0t", $time);
      end
      if (sample_strobe || underrun) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: strobe=%b underrun=%b want none at %0t", sample_strobe, underrun, $time);
        end else begin
          got = sb.pop_front();
          if (got.is_strobe !== sample_strobe || got.is_strobe === underrun) begin
            fails++;
            $display("FAIL pulse_kind: strobe=%b underrun=%b want strobe=%b at %0t", sample_strobe, underrun, got.is_strobe, $time);
          end
        end
      end else if (sb.size() != 0) begin
        tests++;
        fails++;
        got = sb.pop_front();
        $display("FAIL missing_pulse: got none want strobe=%b at %0t", got.is_strobe, $time);
      end
      tests++;
      if (sample_out !== exp_sample) begin
        fails++;
        $display("FAIL sample_out: got %h want %h at %0t", sample_out, exp_sample, $time);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    tests++;
    if (sample_out !== 8'h00 || sample_strobe !== 1'b0 || underrun !== 1'b0 || word_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s: out=%h strobe=%b underrun=%b ready=%b want 00 0 0 1", tag, sample_out, sample_strobe, underrun, word_ready);
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    word_valid = 1'b1;
    word_data  = w;
    step(1);
    word_valid = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 check_reset_vals("reset_initial");
    enable     = 1'b1;
    word_valid = 1'b1;
    freq_count = 32'd1;
    step(4);
    check_reset_vals("reset_held");
    word_valid = 1'b0;
    reset      = 1'b1;
    enable     = 1'b0;

    freq_count = 32'd4;
    step(2);
    enable = 1'b1;
    load_word(32'hDDCCBBAA);
    step(20);

    freq_count = 32'd3;
    step(12);

    freq_count = 32'd1;
    word_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      word_data = $urandom;
      step(1);
    end
    freq_count = 32'd0;
    for (int i = 0; i < 20; i++) begin
      word_data = $urandom;
      step(1);
    end
    word_valid = 1'b0;

    freq_count = 32'd10;
    step(3);
    load_word($urandom);
    step(7);
    freq_count = 32'd2;
    step(10);

    freq_count = 32'd4;
    step(12);
    load_word($urandom);
    step(8);
    enable = 1'b0;
    step(20);
    enable = 1'b1;
    step(12);

    freq_count = 32'd5;
    load_word($urandom);
    step(7);
    @(posedge clk_in);
    #3 reset = 1'b0;
    #1 check_reset_vals("reset_async_midword");
    word_valid = 1'b1;
    step(3);
    check_reset_vals("reset_held2");
    word_valid = 1'b0;
    reset      = 1'b1;
    step(12);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) freq_count = $urandom_range(0, 6);
      enable     = ($urandom_range(0, 9) != 0);
      word_valid = ($urandom_range(0, 2) != 0);
      word_data  = $urandom;
      step(1);
    end

    enable     = 1'b0;
    word_valid = 1'b0;
    step(3);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
